hdmi_pll_lock_mon: RTL and testbench
====================================

HDMI_PLL_LOCK_MON -- requirements
Module: hdmi_pll_lock_mon

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width, in init_clk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: max cycles to wait for lock after reset release (1 ms at 20 ns).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synced-lock cycles required to qualify lock.
REQ-004 SHALL have parameter MAX_RETRY, default 7: reset retries before declaring failure; range 0..15.
REQ-005 init_clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pll_lock  input  1  raw PLL lock, asynchronous to init_clk.
REQ-008 restart  input  1  single-cycle request to re-run the reset sequence.
REQ-009 pll_rst  output  1  reset to PLL, active-high, registered.
REQ-010 locked  output  1  qualified lock, registered.
REQ-011 fail  output  1  retries exhausted, registered.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 retry_cnt  output  4  retries used since last reset/restart/qualified lock.
REQ-014 loss_cnt  output  8  loss-of-lock events, saturating.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer; all decisions use the synced value (lock_s), giving 2 cycles input latency.
REQ-016 FSM states and encodings SHALL be S_RST=0, S_WAIT=1, S_QUAL=2, S_LOCKED=3, S_FAIL=4.
REQ-017 S_RST: pll_rst=1 and the counter runs; after RST_CYCLES cycles in S_RST, go to S_WAIT with the counter cleared.
REQ-018 S_WAIT: pll_rst=0; lock_s=1 -> S_QUAL; if LOCK_TIMEOUT cycles elapse without lock: retry_cnt<MAX_RETRY -> retry_cnt+1, S_RST; else S_FAIL.
REQ-019 S_QUAL: lock_s must stay 1 for STABLE_CYCLES consecutive cycles -> S_LOCKED, retry_cnt cleared; any lock_s=0 -> S_WAIT with the timeout counter restarted (no PLL reset).
REQ-020 S_LOCKED: locked=1; lock_s=0 -> loss_cnt+1 (saturate at 255), locked=0 next cycle, S_RST.
REQ-021 S_FAIL: fail=1, pll_rst=0; state held until restart or reset.
REQ-022 restart=1 in any state SHALL force S_RST next cycle, clear retry_cnt and fail, and clear locked; restart has priority over every other transition.
REQ-023 Simultaneous restart and lock loss in S_LOCKED SHALL NOT increment loss_cnt.
REQ-024 locked and fail SHALL never both be 1.
REQ-025 Counter width SHALL hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) without wrap; the counter clears on every state change.

Reset
REQ-026 reset=1 SHALL set state=S_RST, counter=0, pll_rst=1, locked=0, fail=0, retry_cnt=0, loss_cnt=0, and synchronizer flops=0.
REQ-027 On reset release, the S_RST pulse SHALL last a full RST_CYCLES further cycles; reset asserted mid-sequence restarts it.

Configuration
REQ-028 With HDMI_PLL_LOCK_MON_STATS_EN defined, loss_cnt SHALL operate per REQ-020/023.
REQ-029 Without HDMI_PLL_LOCK_MON_STATS_EN, loss_cnt SHALL be constant 0 with no counter flops; all other behaviour is unchanged.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, STATS_EN defined)
REQ-030 Release reset, then pll_lock=1 from cycle 10 -> pll_rst=1 for exactly 4 cycles after release; locked=1 once lock_s has been 1 for 8 cycles (2-cycle sync latency); retry_cnt=0.
REQ-031 pll_lock held 0 -> three S_RST pulses (retry_cnt 0,1,2), then fail=1, state=4, pll_rst=0 stable.
REQ-032 In S_QUAL, drop pll_lock for 1 cycle at qual count 5 -> state returns to 1, no pll_rst pulse, locked stays 0; re-lock qualifies after a full 8 cycles.
REQ-033 While locked, drop pll_lock 3 times with re-lock each time -> loss_cnt=3, 3 pll_rst pulses of 4 cycles each; restart asserted together with a 4th drop -> loss_cnt stays 3.
REQ-034 From S_FAIL, pulse restart -> fail=0 next cycle, state=0, pll_rst=1 for 4 cycles, retry_cnt=0.
REQ-035 Assert reset mid-S_WAIT -> all outputs match REQ-026 the next cycle; loss_cnt=0.

Source files
------------

// File: rtl/hdmi_pll_lock_mon_if.sv
// Signal bundle between the PLL lock monitor (master) and the PLL/controller side (slave).
interface hdmi_pll_lock_mon_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       locked;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_lock, restart,
    output pll_rst, locked, fail, state, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_lock, restart,
    input  pll_rst, locked, fail, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/hdmi_pll_lock_mon.sv
// HDMI PLL reset sequencer and lock qualifier with bounded retries.
// Define HDMI_PLL_LOCK_MON_STATS_EN to build the saturating loss-of-lock counter.
module hdmi_pll_lock_mon #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic                 init_clk,
  input  logic                 reset,
  hdmi_pll_lock_mon_if.master  bus
);

  localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_QUAL   = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       retry_q, retry_d;
  logic             sync1, lock_s;
  logic             pll_rst_q, locked_q, fail_q;
  logic             pll_rst_d, locked_d, fail_d;

  // NOTE: both stages use non-blocking assignment; blocking would collapse the chain to one flop.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge init_clk) begin
    if (reset) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      // A restart while already in S_RST must still begin a fresh pulse.
      if (state_d != state_q || bus.restart)
        cnt_q <= '0;
      else if (state_q inside {S_RST, S_WAIT, S_QUAL})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (bus.restart) begin
      state_d = S_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RST:    if (cnt_q == RST_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_QUAL;
          end else if (cnt_q == WAIT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_RST;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_QUAL: begin
          if (!lock_s) begin
            state_d = S_WAIT;
          end else if (cnt_q == QUAL_LAST) begin
            state_d = S_LOCKED;
            retry_d = '0;
          end
        end
        S_LOCKED: if (!lock_s) state_d = S_RST;
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_RST;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state register.
  always_comb begin
    pll_rst_d = (state_d == S_RST);
    locked_d  = (state_d == S_LOCKED);
    fail_d    = (state_d == S_FAIL);
  end

`ifdef HDMI_PLL_LOCK_MON_STATS_EN
  logic [7:0] loss_q;
  logic       lost;

  // A restart coinciding with lock loss is a deliberate re-run, not a loss event.
  assign lost = (state_q == S_LOCKED) && !lock_s && !bus.restart;

  always_ff @(posedge init_clk) begin
    if (reset)
      loss_q <= '0;
    else if (lost && loss_q != 8'hFF)
      loss_q <= loss_q + 1'b1;
  end

  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = '0;
`endif

  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.pll_rst   = pll_rst_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;

endmodule

// File: tb/tb_hdmi_pll_lock_mon.sv
// Directed bench for hdmi_pll_lock_mon with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
module tb_hdmi_pll_lock_mon;

`ifdef HDMI_PLL_LOCK_MON_STATS_EN
  localparam logic [7:0] LOSS3 = 8'd3;
`else
  localparam logic [7:0] LOSS3 = 8'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic both_seen = 1'b0;
  logic rst_seen  = 1'b0;

  hdmi_pll_lock_mon_if bus ();

  hdmi_pll_lock_mon #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .init_clk(clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.locked === 1'b1 && bus.fail === 1'b1) both_seen = 1'b1;
    if (bus.pll_rst === 1'b1) rst_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedge samples, starting with the current one, while pll_rst equals lvl.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (bus.pll_rst === lvl && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int i = 0;
    while (bus.state !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(bus.state), 32'(s));
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    step(3);

    check("rst_state",   32'(bus.state), 0);
    check("rst_pll_rst", 32'(bus.pll_rst), 1);
    check("rst_locked",  32'(bus.locked), 0);
    check("rst_fail",    32'(bus.fail), 0);
    check("rst_retry",   32'(bus.retry_cnt), 0);
    check("rst_loss",    32'(bus.loss_cnt), 0);

    // First lock after power-up
    reset = 1'b0;
    measure(1'b1, n);
    check("first_pulse_len", 32'(n), 4);
    check("first_wait_state", 32'(bus.state), 1);
    step(3);
    bus.pll_lock = 1'b1;
    step(10);
    check("qual_not_yet_locked", 32'(bus.locked), 0);
    check("qual_state", 32'(bus.state), 2);
    step(1);
    check("locked_after_qual", 32'(bus.locked), 1);
    check("locked_state", 32'(bus.state), 3);
    check("locked_retry", 32'(bus.retry_cnt), 0);

    // Three loss-of-lock events with re-lock
    for (int k = 0; k < 3; k++) begin
      bus.pll_lock = 1'b0;
      step(1);
      bus.pll_lock = 1'b1;
      step(2);
      check("loss_to_rst", 32'(bus.state), 0);
      check("loss_locked_low", 32'(bus.locked), 0);
      measure(1'b1, n);
      check("loss_pulse_len", 32'(n), 4);
      wait_state("relock", 3'd3, 40);
    end
    check("loss_cnt_3", 32'(bus.loss_cnt), 32'(LOSS3));

    // Fourth drop coincides with restart: not counted
    bus.pll_lock = 1'b0;
    step(2);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("restart_drop_state", 32'(bus.state), 0);
    check("restart_drop_locked", 32'(bus.locked), 0);
    check("restart_drop_loss", 32'(bus.loss_cnt), 32'(LOSS3));
    check("retry0", 32'(bus.retry_cnt), 0);
    measure(1'b1, n);
    check("retry0_pulse_len", 32'(n), 4);

    // Lock never arrives: two retries then failure
    for (int r = 1; r <= 2; r++) begin
      measure(1'b0, n);
      check("timeout_len", 32'(n), 20);
      check("retry_step", 32'(bus.retry_cnt), 32'(r));
      measure(1'b1, n);
      check("retry_pulse_len", 32'(n), 4);
    end
    wait_state("reach_fail", 3'd4, 40);
    check("fail_set", 32'(bus.fail), 1);
    check("fail_pll_rst", 32'(bus.pll_rst), 0);
    check("fail_locked", 32'(bus.locked), 0);
    check("fail_retry", 32'(bus.retry_cnt), 2);
    step(5);
    check("fail_hold_state", 32'(bus.state), 4);
    check("fail_hold_pll_rst", 32'(bus.pll_rst), 0);

    // Restart out of failure
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("restart_fail_clr", 32'(bus.fail), 0);
    check("restart_state", 32'(bus.state), 0);
    check("restart_retry", 32'(bus.retry_cnt), 0);
    measure(1'b1, n);
    check("restart_pulse_len", 32'(n), 4);

    // One-cycle glitch during qualification at count 5
    rst_seen = 1'b0;
    bus.pll_lock = 1'b1;
    step(6);
    bus.pll_lock = 1'b0;
    step(1);
    bus.pll_lock = 1'b1;
    step(1);
    check("glitch_pre_state", 32'(bus.state), 2);
    step(1);
    check("glitch_back_wait", 32'(bus.state), 1);
    check("glitch_locked", 32'(bus.locked), 0);
    step(8);
    check("requal_not_yet", 32'(bus.locked), 0);
    check("requal_state", 32'(bus.state), 2);
    step(1);
    check("requal_locked", 32'(bus.locked), 1);
    check("glitch_no_pll_rst", 32'(rst_seen), 0);

    // Reset asserted in the middle of a wait
    bus.pll_lock = 1'b0;
    wait_state("reach_wait", 3'd1, 20);
    step(3);
    reset = 1'b1;
    step(1);
    check("midrst_state",   32'(bus.state), 0);
    check("midrst_pll_rst", 32'(bus.pll_rst), 1);
    check("midrst_locked",  32'(bus.locked), 0);
    check("midrst_fail",    32'(bus.fail), 0);
    check("midrst_retry",   32'(bus.retry_cnt), 0);
    check("midrst_loss",    32'(bus.loss_cnt), 0);
    reset = 1'b0;
    measure(1'b1, n);
    check("midrst_pulse_len", 32'(n), 4);

    check("locked_and_fail_exclusive", 32'(both_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
